// File: rtl/tc_dma_pkg.sv
// Shared types for the TC fast-RAM DMA engine: FSM states, op encoding and
// the latched command record.
package tc_dma_pkg;

  localparam int unsigned TC_DATA_W = 16;
  localparam int unsigned TC_ADDR_W = 16;
  localparam int unsigned TC_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef struct packed {
    logic                 op;
    logic [TC_ADDR_W-1:0] src;
    logic [TC_ADDR_W-1:0] dst;
    logic [TC_LEN_W-1:0]  len;
    logic [TC_DATA_W-1:0] pattern;
  } cmd_t;

endpackage

// File: rtl/tc_ram_dma.sv
// Copy/fill DMA engine mastering a single-port TC fast RAM with combinational
// reads. One command at a time; copy costs 2 cycles per word, fill 1.
module tc_ram_dma
  import tc_dma_pkg::*;
#(
  // The command record uses the package widths; keep these equal to them.
  parameter int unsigned DATA_W = TC_DATA_W,
  parameter int unsigned ADDR_W = TC_ADDR_W,
  parameter int unsigned LEN_W  = TC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic              load,
  output logic              save,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] out0
);

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [LEN_W-1:0]   words_done_q, words_done_d;
  logic               aborted_q, aborted_d;
  logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]  in0_hold_q, in0_hold_d;
  logic [LEN_W-1:0]   idx_next;
  logic               last_word;

  assign idx_next  = idx_q + 1'b1;
  assign last_word = (idx_next == cmd_q.len);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    data_d       = data_q;
    words_done_d = words_done_q;
    aborted_d    = aborted_q;
    load         = 1'b0;
    save         = 1'b0;
    done         = 1'b0;
    // Outside RD/WR the RAM ignores address/in0; hold them to avoid toggling.
    address      = addr_hold_q;
    in0          = in0_hold_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.op      = cmd_op;
          cmd_d.src     = cmd_src;
          cmd_d.dst     = cmd_dst;
          cmd_d.len     = cmd_len;
          cmd_d.pattern = cmd_pattern;
          idx_d         = '0;
          words_done_d  = '0;
          aborted_d     = 1'b0;
          if (cmd_len == '0)         state_d = FIN;
          else if (cmd_op == OP_FILL) state_d = WR;
          else                        state_d = RD;
        end
      end
      RD: begin
        load    = 1'b1;
        address = cmd_q.src + ADDR_W'(idx_q);
        data_d  = out0;
        if (abort) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        save         = 1'b1;
        address      = cmd_q.dst + ADDR_W'(idx_q);
        in0          = (cmd_q.op == OP_FILL) ? cmd_q.pattern : data_q;
        words_done_d = words_done_q + 1'b1;
        idx_d        = idx_next;
        // A natural finish takes priority, so aborting the last word is not
        // reported as an abort.
        if (last_word) begin
          state_d = FIN;
        end else if (abort) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end else begin
          state_d = (cmd_q.op == OP_FILL) ? WR : RD;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    addr_hold_d = address;
    in0_hold_d  = in0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      words_done_q <= '0;
      aborted_q    <= 1'b0;
      addr_hold_q  <= '0;
      in0_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      words_done_q <= words_done_d;
      aborted_q    <= aborted_d;
      addr_hold_q  <= addr_hold_d;
      in0_hold_q   <= in0_hold_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign aborted    = aborted_q;
  assign words_done = words_done_q;

endmodule

// File: doc/tc_ram_dma.md
Name: tc_ram_dma

Overview:
- Initiator-side engine that drives the load/save/address/in0/out0 port of a single-port TC fast RAM (the responder).
- Accepts one command at a time over a valid/ready port and executes it as a sequence of RAM cycles.
- A command is either a block copy (SRC to DST, LEN words) or a block fill (a constant PATTERN written to DST, LEN words).
- Sits between a CPU/command source and the RAM; it is the only RAM master while busy.

Parameters:
- DATA_W, 16, RAM word width (in0/out0).
- ADDR_W, 16, RAM address width; all address arithmetic is modulo 2^ADDR_W.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command (high only in IDLE).
- cmd_op  in  1  0 = copy, 1 = fill.
- cmd_src  in  ADDR_W  copy source base address (ignored for fill).
- cmd_dst  in  ADDR_W  destination base address.
- cmd_len  in  LEN_W  number of words.
- cmd_pattern  in  DATA_W  fill value (ignored for copy).
- abort  in  1  request early termination.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 = terminated by abort.
- words_done  out  LEN_W  count of words written by the current or last command.
- load  out  1  RAM read strobe.
- save  out  1  RAM write strobe.
- address  out  ADDR_W  RAM address.
- in0  out  DATA_W  RAM write data.
- out0  in  DATA_W  RAM read data.

Behaviour:
- RAM contract: the read is combinational; out0 is valid in the same cycle that load=1 and address are stable, and the engine captures it on that cycle's rising edge. The write occurs on the rising edge of a cycle with save=1. load and save are never both 1.
- Reset (rst=0, async): state=IDLE, cmd_ready=1, busy=0, done=0, aborted=0, words_done=0, load=0, save=0, address=0, in0=0.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - A handshake occurs when cmd_valid and cmd_ready are both 1 at a rising edge.
  - On a handshake, latch op/src/dst/len/pattern, clear idx and words_done, and set busy=1.
  - If len==0, go to FIN. Otherwise go to RD for copy or WR for fill.
- RD (copy only): load=1, address=src+idx. Capture out0 into the data register, then go to WR.
- WR:
  - save=1, address=dst+idx, in0 = data register (copy) or pattern (fill).
  - On the edge: words_done+1 and idx+1.
  - If idx+1==len, go to FIN. Otherwise go to RD (copy) or stay in WR (fill).
- FIN: done=1 for exactly one cycle, busy=0 on the next cycle, then IDLE. cmd_ready returns to 1 in IDLE, so back-to-back commands have at most 1 idle cycle.
- Throughput: copy takes 2 cycles per word; fill takes 1 cycle per word. Latency from handshake to done: copy 2*len+1 cycles, fill len+1 cycles, len=0 gives 1 cycle.
- Outputs while not in RD/WR: load=0, save=0. address and in0 hold their last values; the RAM must not care about them.
- Address wrap: src+idx and dst+idx wrap modulo 2^ADDR_W, e.g. dst=0xFFFF, len=2 writes 0xFFFF then 0x0000.
- Overlap: copies always run in ascending order. When dst > src and the regions overlap, source words are overwritten before they are read; this is defined behaviour, not an error.
- abort:
  - Sampled only in RD/WR.
  - In RD: the read is discarded and no further write occurs; go to FIN with aborted=1.
  - In WR: the current write completes and is counted; go to FIN with aborted=1.
  - In IDLE/FIN: ignored.
  - If abort and the natural last word coincide, aborted=0.
- aborted holds its value until the next handshake. words_done holds until the next handshake.
- cmd_* inputs are ignored when cmd_ready=0.
- Reset mid-command: immediate return to IDLE and reset values. A partially executed command is not resumed.

Decomposition:
- Shared package tc_dma_pkg holds:
  - the state enum (IDLE, RD, WR, FIN);
  - the op encoding constants OP_COPY=0 and OP_FILL=1;
  - a command struct {op, src, dst, len, pattern} parameterised by the widths.
- Single module, no sub-modules. An address-offset adder pair is inline logic.

Test Plan:
- Fill: dst=0x0010, len=3, pattern=0xABCD. Expect save high on 3 consecutive cycles at 0x0010..0x0012, in0=0xABCD, then done, aborted=0, words_done=3.
- Copy: preload RAM[0]=0x0001 and RAM[1]=0x0002. Copy src=0, dst=0x0100, len=2. Expect the cycle sequence load@0, save@0x100=0x0001, load@1, save@0x101=0x0002. done asserts 5 cycles after the handshake.
- len=0 (copy and fill): no load/save pulses; done asserts 1 cycle after the handshake; words_done=0.
- Wrap: fill with dst=0xFFFF, len=2, pattern=0x5A5A. Expect writes to 0xFFFF and then 0x0000.
- Abort:
  - Copy len=4 with abort asserted during the 2nd RD cycle: words_done=1, aborted=1, RAM[dst+1] unchanged.
  - Abort asserted during the WR of the last word: aborted=0, words_done=4.
- Reset/handshake:
  - Drive rst=0 asynchronously mid-fill: outputs reach reset values before the next edge, with no further saves.
  - Hold cmd_valid high while busy: exactly one command is accepted; a second command is accepted in IDLE right after done.
